// File: rtl/mul_div_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mul_div_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [1:0] op);
    return (op != OP_MULTU) && (op != OP_MULT);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Two's-complement conditional negation: data_o = neg_i ? -data_i : data_i.
module cond_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/iterative_mul_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers; one iteration per cycle on
// magnitudes, sign fix-up in a final cycle.
module iterative_mul_div
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign sgn = is_signed(op);

  cond_negate #(.WIDTH(WIDTH)) u_abs_a (
    .neg_i  (sgn & a[WIDTH-1]),
    .data_i (a),
    .data_o (abs_a)
  );

  cond_negate #(.WIDTH(WIDTH)) u_abs_b (
    .neg_i  (sgn & b[WIDTH-1]),
    .data_i (b),
    .data_o (abs_b)
  );

  cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg_i  (neg_res_q),
    .data_i (acc_q),
    .data_o (prod_fix)
  );

  cond_negate #(.WIDTH(WIDTH)) u_fix_quot (
    .neg_i  (neg_res_q),
    .data_i (acc_q[WIDTH-1:0]),
    .data_o (quot_fix)
  );

  cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i  (neg_rem_q),
    .data_i (acc_q[2*WIDTH-1:WIDTH]),
    .data_o (rem_fix)
  );

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          state_d   = CALC;
          cnt_d     = CNT_W'(WIDTH);
          div_d     = is_div(op);
          neg_res_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = sgn & a[WIDTH-1];
          zero_d    = is_div(op) && (b == '0);
          a_raw_d   = a;
          if (is_div(op)) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            opnd_d = abs_a;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = zero_q;
        if (zero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else if (div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush leaves the architectural HI/LO state untouched.
    if (cancel) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_iterative_mul_div.sv
// Bench for iterative_mul_div at WIDTH=32 (index 0) and WIDTH=8 (index 1) against an
// arithmetic transaction model plus hand-computed expectations.
module tb_iterative_mul_div;
  import mul_div_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_v[2], cancel_v[2], hi_we_v[2], lo_we_v[2];
  logic [1:0]  op_v[2];
  logic [31:0] a_v[2], b_v[2], wdata_v[2];

  logic        busy32, done32, dbz32, busy8, done8, dbz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  logic        busy_o[2], done_o[2], dbz_o[2];
  logic [31:0] hi_o[2], lo_o[2];

  int n_pass  = 0;
  int n_total = 0;

  iterative_mul_div #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .a(a_v[0]), .b(b_v[0]),
    .cancel(cancel_v[0]), .hi_we(hi_we_v[0]), .lo_we(lo_we_v[0]), .wdata(wdata_v[0]),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  iterative_mul_div #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .a(a_v[1][7:0]),
    .b(b_v[1][7:0]), .cancel(cancel_v[1]), .hi_we(hi_we_v[1]), .lo_we(lo_we_v[1]),
    .wdata(wdata_v[1][7:0]), .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8),
    .lo(lo8)
  );

  always_comb begin
    busy_o[0] = busy32; done_o[0] = done32; dbz_o[0] = dbz32; hi_o[0] = hi32; lo_o[0] = lo32;
    busy_o[1] = busy8;  done_o[1] = done8;  dbz_o[1] = dbz8;
    hi_o[1]   = {24'd0, hi8};
    lo_o[1]   = {24'd0, lo8};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic int wid(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] msk(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Plain-arithmetic reference for one operation at width w.
  function automatic res_t model_op(input int w, input logic [1:0] o, input logic [31:0] x_in,
                                    input logic [31:0] y_in);
    res_t        r;
    logic [31:0] m, x, y;
    longint      sx, sy, p, q, rm;
    logic [63:0] pu;
    m  = msk(w);
    x  = x_in & m;
    y  = y_in & m;
    sx = longint'(x);
    sy = longint'(y);
    if (o == OP_MULT || o == OP_DIV) begin
      if (x[w-1]) sx -= (longint'(1) <<< w);
      if (y[w-1]) sy -= (longint'(1) <<< w);
    end
    r.dbz = 1'b0;
    if (o == OP_MULTU || o == OP_MULT) begin
      p    = sx * sy;
      pu   = p;
      r.hi = 32'(pu >> w) & m;
      r.lo = pu[31:0] & m;
    end else if (y == 32'd0) begin
      r.hi  = x;
      r.lo  = m;
      r.dbz = 1'b1;
    end else begin
      q    = sx / sy;
      rm   = sx % sy;
      r.lo = 32'(q) & m;
      r.hi = 32'(rm) & m;
    end
    return r;
  endfunction

  // Transaction-level model: busy for w+1 cycles after an accepted start, then results land.
  int          m_busy[2];
  logic        m_done[2], m_dbz[2];
  logic [31:0] m_hi[2], m_lo[2];
  res_t        r_res[2];

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_busy[d] <= 0;
        m_done[d] <= 1'b0;
        m_dbz[d]  <= 1'b0;
        m_hi[d]   <= 32'd0;
        m_lo[d]   <= 32'd0;
      end else begin
        m_done[d] <= 1'b0;
        if (cancel_v[d]) begin
          m_busy[d] <= 0;
        end else if (m_busy[d] > 0) begin
          m_busy[d] <= m_busy[d] - 1;
          if (m_busy[d] == 1) begin
            m_hi[d]   <= r_res[d].hi;
            m_lo[d]   <= r_res[d].lo;
            m_dbz[d]  <= r_res[d].dbz;
            m_done[d] <= 1'b1;
          end
        end else if (start_v[d]) begin
          r_res[d]  <= model_op(wid(d), op_v[d], a_v[d], b_v[d]);
          m_busy[d] <= wid(d) + 1;
        end else begin
          if (hi_we_v[d]) m_hi[d] <= wdata_v[d] & msk(wid(d));
          if (lo_we_v[d]) m_lo[d] <= wdata_v[d] & msk(wid(d));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("w%0d busy", wid(d)), 32'(busy_o[d]), 32'(m_busy[d] > 0));
        chk($sformatf("w%0d done", wid(d)), 32'(done_o[d]), 32'(m_done[d]));
        chk($sformatf("w%0d dbz", wid(d)), 32'(dbz_o[d]), 32'(m_dbz[d]));
        chk($sformatf("w%0d hi", wid(d)), hi_o[d], m_hi[d]);
        chk($sformatf("w%0d lo", wid(d)), lo_o[d], m_lo[d]);
      end
    end
  end

  // Entered and left on a falling edge; returns the number of busy cycles seen.
  task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int nb);
    op_v[d]    = o;
    a_v[d]     = x;
    b_v[d]     = y;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    wait_done(d, nb);
  endtask

  task automatic wait_done(input int d, output int nb);
    int guard;
    nb    = 0;
    guard = 0;
    while (!done_o[d] && guard < 200) begin
      if (busy_o[d]) nb++;
      guard++;
      @(negedge clk);
    end
    chk($sformatf("w%0d done within bound", wid(d)), 32'(done_o[d]), 32'd1);
  endtask

  int nb, pulses;

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; cancel_v[d] = 1'b0; hi_we_v[d] = 1'b0; lo_we_v[d] = 1'b0;
      op_v[d] = 2'b00; a_v[d] = 32'd0; b_v[d] = 32'd0; wdata_v[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy32), 32'd0);
    chk("reset done", 32'(done32), 32'd0);
    chk("reset hi", hi32, 32'd0);
    chk("reset lo", lo32, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
    chk("multu busy cycles", 32'(nb), 32'd33);
    chk("multu hi", hi32, 32'hFFFF_FFFE);
    chk("multu lo", lo32, 32'h0000_0001);
    run_op(0, OP_MULT, -32'sd7, 32'd6, nb);
    chk("mult hi", hi32, 32'hFFFF_FFFF);
    chk("mult lo", lo32, 32'hFFFF_FFD6);
    run_op(0, OP_DIV, -32'sd7, 32'd2, nb);
    chk("div lo", lo32, 32'hFFFF_FFFD);
    chk("div hi", hi32, 32'hFFFF_FFFF);
    run_op(0, OP_DIVU, 32'd100, 32'd0, nb);
    chk("divu0 busy cycles", 32'(nb), 32'd33);
    chk("divu0 lo", lo32, 32'hFFFF_FFFF);
    chk("divu0 hi", hi32, 32'd100);
    chk("divu0 dbz", 32'(dbz32), 32'd1);
    run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("div ovf lo", lo32, 32'h8000_0000);
    chk("div ovf hi", hi32, 32'd0);
    chk("div ovf dbz", 32'(dbz32), 32'd0);

    // Cancel mid-operation: no result, HI/LO untouched.
    op_v[0] = OP_MULTU; a_v[0] = 32'd3; b_v[0] = 32'd5; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    cancel_v[0] = 1'b1;
    @(negedge clk);
    cancel_v[0] = 1'b0;
    chk("cancel busy", 32'(busy32), 32'd0);
    chk("cancel hi kept", hi32, 32'd0);
    chk("cancel lo kept", lo32, 32'h8000_0000);
    pulses = 0;
    repeat (40) begin
      if (done32) pulses++;
      @(negedge clk);
    end
    chk("cancel no done", 32'(pulses), 32'd0);
    run_op(0, OP_MULTU, 32'd3, 32'd5, nb);
    chk("after cancel lo", lo32, 32'd15);

    hi_we_v[0] = 1'b1; wdata_v[0] = 32'h1234;
    @(negedge clk);
    hi_we_v[0] = 1'b0;
    chk("mthi", hi32, 32'h1234);

    // lo_we and a second start while busy are both dropped.
    op_v[0] = OP_MULTU; a_v[0] = 32'd2; b_v[0] = 32'd3; start_v[0] = 1'b1;
    @(negedge clk);
    op_v[0] = OP_DIVU; a_v[0] = 32'd9; lo_we_v[0] = 1'b1; wdata_v[0] = 32'hDEAD;
    @(negedge clk);
    start_v[0] = 1'b0; lo_we_v[0] = 1'b0;
    wait_done(0, nb);
    pulses = 0;
    repeat (40) begin
      if (done32) pulses++;
      @(negedge clk);
    end
    chk("single done pulse", 32'(pulses), 32'd1);
    chk("busy-start ignored lo", lo32, 32'd6);

    // start wins over a simultaneous MTHI.
    hi_we_v[0] = 1'b1; wdata_v[0] = 32'h5555;
    run_op(0, OP_MULTU, 32'd4, 32'd4, nb);
    hi_we_v[0] = 1'b0;
    chk("start beats mthi hi", hi32, 32'd0);
    chk("start beats mthi lo", lo32, 32'd16);

    // Asynchronous reset in the middle of CALC.
    op_v[0] = OP_DIVU; a_v[0] = 32'd1000; b_v[0] = 32'd7; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst busy", 32'(busy32), 32'd0);
    chk("async rst done", 32'(done32), 32'd0);
    chk("async rst hi", hi32, 32'd0);
    chk("async rst lo", lo32, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    run_op(1, OP_MULTU, 32'hFF, 32'hFF, nb);
    chk("w8 multu busy cycles", 32'(nb), 32'd9);
    chk("w8 multu hi", {24'd0, hi8}, 32'hFE);
    chk("w8 multu lo", {24'd0, lo8}, 32'h01);
    run_op(1, OP_MULT, 32'hF9, 32'd6, nb);
    chk("w8 mult hi", {24'd0, hi8}, 32'hFF);
    chk("w8 mult lo", {24'd0, lo8}, 32'hD6);
    run_op(1, OP_DIV, 32'hF9, 32'd2, nb);
    chk("w8 div lo", {24'd0, lo8}, 32'hFD);
    chk("w8 div hi", {24'd0, hi8}, 32'hFF);
    run_op(1, OP_DIVU, 32'd100, 32'd0, nb);
    chk("w8 divu0 busy cycles", 32'(nb), 32'd9);
    chk("w8 divu0 hi", {24'd0, hi8}, 32'd100);
    chk("w8 divu0 lo", {24'd0, lo8}, 32'hFF);
    chk("w8 divu0 dbz", 32'(dbz8), 32'd1);
    run_op(1, OP_DIV, 32'h80, 32'hFF, nb);
    chk("w8 div ovf lo", {24'd0, lo8}, 32'h80);
    chk("w8 div ovf hi", {24'd0, hi8}, 32'd0);
    chk("w8 div ovf dbz", 32'(dbz8), 32'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
